// File: rtl/knightrider_decoder_pkg.sv
// Shared encodings for the knightrider LED-bus decoder: FSM states, fault codes, direction values.
package knightrider_decoder_pkg;

   typedef enum logic [1:0] {
      ST_ACQ0  = 2'd0,
      ST_ACQ1  = 2'd1,
      ST_TRACK = 2'd2,
      ST_FAULT = 2'd3
   } kr_state_e;

   localparam logic [1:0] ERR_NONE       = 2'd0;
   localparam logic [1:0] ERR_NOT_ONEHOT = 2'd1;
   localparam logic [1:0] ERR_STALL      = 2'd2;
   localparam logic [1:0] ERR_JUMP       = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/knightrider_decoder_onehot.sv
// onehot_index: combinational LED bus -> lit index plus a one-hot flag (0 for all-zero or multi-bit).
// Latency: none (pure combinational). No backpressure.
module onehot_index #(
   parameter int W = 8
) (
   input  logic [W-1:0]         leds,
   output logic [$clog2(W)-1:0] idx,
   output logic                 is_onehot
);
   localparam int IW = $clog2(W);

   always_comb begin
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (leds[i]) idx = IW'(i);
      end
   end

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   assign is_onehot = (leds != '0) && ((leds & (leds - W'(1))) == '0);

endmodule

// File: rtl/knightrider_decoder.sv
// knightrider_decoder: checks the LED bus against the one-hot bounce sequence; recovers pos/dir, counts reversals.
// Latency: registered outputs, 1 cycle after the sampling edge. No backpressure; en qualifies each sample.
// KR_DEC_RESYNC_EN: FAULT re-acquires on the next one-hot sample and fault_cnt is exported.
module knightrider_decoder
   import knightrider_decoder_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 en,
   input  logic [W-1:0]         leds,
   output logic [$clog2(W)-1:0] pos,
   output logic                 dir,
   output logic                 locked,
   output logic                 err,
   output logic [1:0]           err_code,
`ifdef KR_DEC_RESYNC_EN
   output logic [CNT_W-1:0]     fault_cnt,
`endif
   output logic [CNT_W-1:0]     bounce_cnt
);
   localparam int               PW      = $clog2(W);
   localparam logic [PW-1:0]    POS_MAX = PW'(W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   kr_state_e        state_q, state_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [CNT_W-1:0] bounce_q, bounce_d;
`ifdef KR_DEC_RESYNC_EN
   logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
`endif

   logic [PW-1:0]    idx;
   logic             is_onehot;
   logic [PW-1:0]    pred_pos;
   logic             pred_dir;
   logic             pred_flip;
   logic [1:0]       fault_code;

   onehot_index #(.W(W)) u_onehot (
      .leds      (leds),
      .idx       (idx),
      .is_onehot (is_onehot)
   );

   // Next expected position; at either end the sweep reflects and direction flips.
   always_comb begin
      pred_pos  = pos_q;
      pred_dir  = dir_q;
      pred_flip = 1'b0;
      if (dir_q == DIR_UP) begin
         if (pos_q == POS_MAX) begin
            pred_pos  = POS_MAX - PW'(1);
            pred_dir  = DIR_DOWN;
            pred_flip = 1'b1;
         end else begin
            pred_pos  = pos_q + PW'(1);
         end
      end else begin
         if (pos_q == '0) begin
            pred_pos  = PW'(1);
            pred_dir  = DIR_UP;
            pred_flip = 1'b1;
         end else begin
            pred_pos  = pos_q - PW'(1);
         end
      end
   end

   always_comb begin
      if (!is_onehot)          fault_code = ERR_NOT_ONEHOT;
      else if (idx == pos_q)   fault_code = ERR_STALL;
      else if (idx != pred_pos) fault_code = ERR_JUMP;
      else                     fault_code = ERR_NONE;
   end

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      locked_d   = locked_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      bounce_d   = bounce_q;
`ifdef KR_DEC_RESYNC_EN
      fault_cnt_d = fault_cnt_q;
`endif
      if (en) begin
         case (state_q)
            ST_ACQ0: begin
               if (is_onehot) begin
                  pos_d   = idx;
                  state_d = ST_ACQ1;
               end
            end
            ST_ACQ1: begin
               if (is_onehot && (pos_q != POS_MAX) && (idx == pos_q + PW'(1))) begin
                  pos_d    = idx;
                  dir_d    = DIR_UP;
                  locked_d = 1'b1;
                  state_d  = ST_TRACK;
               end else if (is_onehot && (pos_q != '0) && (idx == pos_q - PW'(1))) begin
                  pos_d    = idx;
                  dir_d    = DIR_DOWN;
                  locked_d = 1'b1;
                  state_d  = ST_TRACK;
               end else if (is_onehot) begin
                  pos_d    = idx;
               end else begin
                  state_d  = ST_ACQ0;
               end
            end
            ST_TRACK: begin
               if (fault_code != ERR_NONE) begin
                  err_d      = 1'b1;
                  err_code_d = fault_code;
                  locked_d   = 1'b0;
                  state_d    = ST_FAULT;
`ifdef KR_DEC_RESYNC_EN
                  if (fault_cnt_q != CNT_MAX) fault_cnt_d = fault_cnt_q + CNT_W'(1);
`endif
               end else begin
                  pos_d = idx;
                  dir_d = pred_dir;
                  if (pred_flip && (bounce_q != CNT_MAX)) bounce_d = bounce_q + CNT_W'(1);
               end
            end
            ST_FAULT: begin
`ifdef KR_DEC_RESYNC_EN
               if (is_onehot) begin
                  pos_d   = idx;
                  state_d = ST_ACQ1;
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q    <= ST_ACQ0;
         pos_q      <= '0;
         dir_q      <= DIR_UP;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         bounce_q   <= '0;
`ifdef KR_DEC_RESYNC_EN
         fault_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         bounce_q   <= bounce_d;
`ifdef KR_DEC_RESYNC_EN
         fault_cnt_q <= fault_cnt_d;
`endif
      end
   end

   assign pos        = pos_q;
   assign dir        = dir_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign bounce_cnt = bounce_q;
`ifdef KR_DEC_RESYNC_EN
   assign fault_cnt  = fault_cnt_q;
`endif

endmodule

// File: tb/tb_knightrider_decoder.sv
// Bench for knightrider_decoder (W=8, narrow counters so saturation is reachable).
module tb_knightrider_decoder;
   localparam int W     = 8;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk  = 1'b0;
   logic             arst = 1'b1;
   logic             en   = 1'b0;
   logic [W-1:0]     leds = '0;
   logic [2:0]       pos;
   logic             dir, locked, err;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] bounce_cnt;
`ifdef KR_DEC_RESYNC_EN
   logic [CNT_W-1:0] fault_cnt;
`endif

   knightrider_decoder #(.W(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .arst       (arst),
      .en         (en),
      .leds       (leds),
      .pos        (pos),
      .dir        (dir),
      .locked     (locked),
      .err        (err),
      .err_code   (err_code),
`ifdef KR_DEC_RESYNC_EN
      .fault_cnt  (fault_cnt),
`endif
      .bounce_cnt (bounce_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pos;
      int dir;
      int locked;
      int err;
      int code;
      int bounce;
      int fcnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: phase 0=searching, 1=one candidate seen, 2=tracking, 3=faulted.
   int m_phase, m_pos, m_dir, m_locked, m_err, m_code, m_bounce, m_fcnt;

   // One full bounce of the lit position.
   int sweep [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
   int k;
   logic [7:0] last_v;

   function automatic logic [7:0] legal(input int kk);
      logic [7:0] v;
      v = 8'd1 << sweep[kk % 14];
      return v;
   endfunction

   task automatic model_step(input logic a, input logic e, input logic [7:0] v);
      int n, idx, stp, nxt, code;
      bit flip;
      if (a) begin
         m_phase = 0; m_pos = 0; m_dir = 0; m_locked = 0;
         m_err = 0; m_code = 0; m_bounce = 0; m_fcnt = 0;
         return;
      end
      if (!e) return;
      n   = $countones(v);
      idx = -1;
      for (int i = 0; i < W; i++) if (n == 1 && v[i]) idx = i;
      case (m_phase)
         0: if (n == 1) begin m_pos = idx; m_phase = 1; end
         1: begin
            if (n == 1 && (idx == m_pos + 1 || idx == m_pos - 1)) begin
               m_dir = (idx < m_pos) ? 1 : 0;
               m_pos = idx; m_locked = 1; m_phase = 2;
            end else if (n == 1) m_pos = idx;
            else m_phase = 0;
         end
         2: begin
            stp  = (m_dir == 1) ? -1 : 1;
            nxt  = m_pos + stp;
            flip = 0;
            if (nxt < 0 || nxt > W - 1) begin nxt = m_pos - stp; flip = 1; end
            code = 0;
            if (n != 1) code = 1;
            else if (idx == m_pos) code = 2;
            else if (idx != nxt) code = 3;
            if (code != 0) begin
               m_err = 1; m_code = code; m_locked = 0; m_phase = 3;
               if (m_fcnt < CMAX) m_fcnt++;
            end else begin
               m_pos = idx;
               if (flip) begin
                  m_dir = 1 - m_dir;
                  if (m_bounce < CMAX) m_bounce++;
               end
            end
         end
         default: begin
`ifdef KR_DEC_RESYNC_EN
            if (n == 1) begin m_pos = idx; m_phase = 1; end
`endif
         end
      endcase
   endtask

   task automatic step(input logic a, input logic e, input logic [7:0] v);
      exp_t x;
      @(negedge clk);
      arst = a; en = e; leds = v;
      model_step(a, e, v);
      x.pos = m_pos; x.dir = m_dir; x.locked = m_locked; x.err = m_err;
      x.code = m_code; x.bounce = m_bounce; x.fcnt = m_fcnt;
      sb.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
      end
   endtask

   // Monitor: every cycle the registered outputs are checked against the oldest queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("pos",        32'(pos),        x.pos);
            chk("dir",        32'(dir),        x.dir);
            chk("locked",     32'(locked),     x.locked);
            chk("err",        32'(err),        x.err);
            chk("err_code",   32'(err_code),   x.code);
            chk("bounce_cnt", 32'(bounce_cnt), x.bounce);
`ifdef KR_DEC_RESYNC_EN
            chk("fault_cnt",  32'(fault_cnt),  x.fcnt);
`endif
         end
      end
   end

   initial begin
      logic [7:0] v;
      logic       e;
      int         n, c;
      last_v = 8'h00;

      // Reset state, then a clean legal stream covering full sweeps.
      step(1, 0, 8'h00);
      step(1, 1, 8'h55);
      for (int i = 0; i < 40; i++) step(0, 1, legal(i));

      // Stall after two samples, then more samples that must be ignored or resync.
      step(1, 0, 8'h00);
      step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h02);
      step(0, 1, 8'h04); step(0, 1, 8'h00);

      // Jump, then a multi-bit sample after the fault.
      step(1, 0, 8'h00);
      step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h04); step(0, 1, 8'h10);
      step(0, 1, 8'h18);
      // Multi-bit sample as the first fault.
      step(1, 0, 8'h00);
      step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h04); step(0, 1, 8'h18);
      // Resync path: legal stream after a fault.
      step(0, 1, 8'h08); step(0, 1, 8'h10); step(0, 1, 8'h20); step(0, 1, 8'h40);

      // Acquisition corner cases: restart, no wrap between ends, zero sample.
      step(1, 0, 8'h00);
      step(0, 1, 8'h00); step(0, 1, 8'h01); step(0, 1, 8'h04); step(0, 1, 8'h08);
      step(1, 0, 8'h00);
      step(0, 1, 8'h01); step(0, 1, 8'h80); step(0, 1, 8'h00); step(0, 1, 8'h80);
      step(0, 1, 8'h40); step(0, 1, 8'h20);

      // en toggling: random junk on en=0 cycles must be ignored.
      step(1, 0, 8'h00);
      k = 0;
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 1) begin step(0, 1, legal(k)); k++; end
         else step(0, 0, 8'($urandom));
      end

      // Reset mid-TRACK with en high, then descending acquisition from the top.
      step(1, 0, 8'h00);
      for (int i = 0; i < 10; i++) step(0, 1, legal(i));
      step(1, 1, legal(10));
      step(0, 1, 8'h80); step(0, 1, 8'h40); step(0, 1, 8'h20);

      // Long legal run: bounce counter saturates.
      step(1, 0, 8'h00);
      for (int i = 0; i < 150; i++) step(0, 1, legal(i + 3));

      // Randomized rounds with occasional corruption.
      for (int r = 0; r < 25; r++) begin
         step(1, 1'($urandom_range(0, 1)), 8'($urandom));
         k = $urandom_range(0, 13);
         n = $urandom_range(20, 60);
         for (int i = 0; i < n; i++) begin
            e = ($urandom_range(0, 9) != 0);
            if (!e) step(0, 0, 8'($urandom));
            else begin
               c = $urandom_range(0, 29);
               case (c)
                  0:       v = last_v;
                  1:       v = 8'd1 << $urandom_range(0, 7);
                  2:       v = 8'h00;
                  3:       v = legal(k) | (8'd1 << $urandom_range(0, 7));
                  4:       v = 8'($urandom);
                  default: begin v = legal(k); k++; end
               endcase
               last_v = v;
               step(0, 1, v);
            end
         end
      end

      // Long unreset run with frequent corruption (fault counter saturation when resync exists).
      step(1, 0, 8'h00);
      k = 0;
      for (int i = 0; i < 300; i++) begin
         c = $urandom_range(0, 9);
         if (c == 0) v = last_v;
         else if (c == 1) v = 8'd1 << $urandom_range(0, 7);
         else begin v = legal(k); k++; end
         last_v = v;
         step(0, 1, v);
      end

      step(0, 0, 8'h00);
      @(posedge clk);
      #3;
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
